// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at tail, marks done on writeback, retires from head
// and pulses a physical-register release mask. Define ROB_DUAL_RETIRE_EN for two retires/cycle.
module reorder_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PREG_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alloc_valid,
  input  logic              alloc_has_dest,
  input  logic [PREG_W-1:0] alloc_dr_p,
  input  logic [PREG_W-1:0] alloc_old_dr,
  output logic              alloc_ready,
  output logic [15:0]       alloc_tag,
  input  logic              cmpl_valid,
  input  logic [15:0]       cmpl_tag,
  output logic [63:0]       retire_preg_mask,
  output logic [1:0]        retire_count,
  output logic              rob_empty
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned TAG_W  = 16;
  localparam int unsigned MASK_W = 64;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, has_dest_q, has_dest_d;
  logic [PREG_W-1:0] dr_p_q [DEPTH];
  logic [PREG_W-1:0] dr_p_d [DEPTH];
  logic [PREG_W-1:0] old_dr_q [DEPTH];
  logic [PREG_W-1:0] old_dr_d [DEPTH];
  logic [MASK_W-1:0] retire_preg_mask_q, retire_preg_mask_d;
  logic [1:0]        retire_count_q, retire_count_d;

  logic [PTR_W-1:0]  count_c;
  logic              full_c;
  logic [IDX_W-1:0]  head_idx_c, tail_idx_c, cmpl_idx_c;
  logic              ret0_c, ret1_c;
  logic              unused_cmpl_tag_hi;

  assign count_c    = PTR_W'(tail_q - head_q);
  assign full_c     = (count_c == PTR_W'(DEPTH));
  assign head_idx_c = head_q[IDX_W-1:0];
  assign tail_idx_c = tail_q[IDX_W-1:0];
  assign cmpl_idx_c = cmpl_tag[IDX_W-1:0];
  assign unused_cmpl_tag_hi = ^cmpl_tag[TAG_W-1:IDX_W];

  assign alloc_ready      = !full_c;
  assign alloc_tag        = TAG_W'(tail_idx_c);
  assign rob_empty        = (count_c == '0);
  assign retire_preg_mask = retire_preg_mask_q;
  assign retire_count     = retire_count_q;

`ifdef ROB_DUAL_RETIRE_EN
  logic [IDX_W-1:0] head1_idx_c;
  assign head1_idx_c = IDX_W'(head_idx_c + IDX_W'(1));
`endif

  // Order matters: completion, then retire clears, then allocation writes.
  always_comb begin
    head_d             = head_q;
    tail_d             = tail_q;
    valid_d            = valid_q;
    done_d             = done_q;
    has_dest_d         = has_dest_q;
    dr_p_d             = dr_p_q;
    old_dr_d           = old_dr_q;
    retire_preg_mask_d = '0;
    retire_count_d     = '0;
    ret0_c             = valid_q[head_idx_c] && done_q[head_idx_c];
    ret1_c             = 1'b0;
`ifdef ROB_DUAL_RETIRE_EN
    ret1_c = ret0_c && valid_q[head1_idx_c] && done_q[head1_idx_c];
`endif

    if (cmpl_valid && valid_q[cmpl_idx_c]) begin
      done_d[cmpl_idx_c] = 1'b1;
    end

    if (ret0_c) begin
      valid_d[head_idx_c] = 1'b0;
      done_d[head_idx_c]  = 1'b0;
      if (has_dest_q[head_idx_c] && (old_dr_q[head_idx_c] != '0)) begin
        retire_preg_mask_d = retire_preg_mask_d | (MASK_W'(1) << old_dr_q[head_idx_c]);
      end
      retire_count_d = 2'd1;
      head_d         = PTR_W'(head_q + PTR_W'(1));
    end

`ifdef ROB_DUAL_RETIRE_EN
    if (ret1_c) begin
      valid_d[head1_idx_c] = 1'b0;
      done_d[head1_idx_c]  = 1'b0;
      if (has_dest_q[head1_idx_c] && (old_dr_q[head1_idx_c] != '0)) begin
        retire_preg_mask_d = retire_preg_mask_d | (MASK_W'(1) << old_dr_q[head1_idx_c]);
      end
      retire_count_d = 2'd2;
      head_d         = PTR_W'(head_q + PTR_W'(2));
    end
`endif

    if (alloc_valid && !full_c) begin
      valid_d[tail_idx_c]    = 1'b1;
      done_d[tail_idx_c]     = 1'b0;
      has_dest_d[tail_idx_c] = alloc_has_dest;
      dr_p_d[tail_idx_c]     = alloc_dr_p;
      old_dr_d[tail_idx_c]   = alloc_old_dr;
      tail_d                 = PTR_W'(tail_q + PTR_W'(1));
    end
  end

  // Control state with synchronous reset; in-flight entries are dropped, not released.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q             <= '0;
      tail_q             <= '0;
      valid_q            <= '0;
      done_q             <= '0;
      retire_preg_mask_q <= '0;
      retire_count_q     <= '0;
    end else begin
      head_q             <= head_d;
      tail_q             <= tail_d;
      valid_q            <= valid_d;
      done_q             <= done_d;
      retire_preg_mask_q <= retire_preg_mask_d;
      retire_count_q     <= retire_count_d;
    end
  end

  // Payload storage is qualified by valid and needs no reset.
  always_ff @(posedge clk) begin
    has_dest_q <= has_dest_d;
    dr_p_q     <= dr_p_d;
    old_dr_q   <= old_dr_d;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: queue-based program-order model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rstn;
  logic        alloc_valid;
  logic        alloc_has_dest;
  logic [5:0]  alloc_dr_p;
  logic [5:0]  alloc_old_dr;
  logic        alloc_ready;
  logic [15:0] alloc_tag;
  logic        cmpl_valid;
  logic [15:0] cmpl_tag;
  logic [63:0] retire_preg_mask;
  logic [1:0]  retire_count;
  logic        rob_empty;

  int checks;
  int failures;

  reorder_buffer #(.DEPTH(16), .PREG_W(6)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .alloc_valid      (alloc_valid),
    .alloc_has_dest   (alloc_has_dest),
    .alloc_dr_p       (alloc_dr_p),
    .alloc_old_dr     (alloc_old_dr),
    .alloc_ready      (alloc_ready),
    .alloc_tag        (alloc_tag),
    .cmpl_valid       (cmpl_valid),
    .cmpl_tag         (cmpl_tag),
    .retire_preg_mask (retire_preg_mask),
    .retire_count     (retire_count),
    .rob_empty        (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: in-flight instructions as a queue, oldest first.
  typedef struct {
    int tag;
    bit has_dest;
    int old_dr;
    bit done;
  } ent_t;

  ent_t        mq[$];
  int          m_tail;
  logic [63:0] m_mask;
  int          m_cnt;
  bit          model_ok;
  bit          m_full;
  logic [63:0] m_mk;
  int          m_n;
  int          m_lim;
  int          m_ctag;

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_tail = 0;
      m_mask = '0;
      m_cnt  = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_mk   = '0;
      m_n    = 0;
      m_lim  = 1;
`ifdef ROB_DUAL_RETIRE_EN
      m_lim  = 2;
`endif
      while (m_n < m_lim && mq.size() > 0 && mq[0].done) begin
        if (mq[0].has_dest && mq[0].old_dr != 0) m_mk[mq[0].old_dr] = 1'b1;
        void'(mq.pop_front());
        m_n++;
      end
      if (cmpl_valid) begin
        m_ctag = int'(cmpl_tag) % DEPTH;
        foreach (mq[i]) if (mq[i].tag == m_ctag) mq[i].done = 1'b1;
      end
      if (alloc_valid && !m_full) begin
        mq.push_back('{tag: m_tail, has_dest: alloc_has_dest, old_dr: int'(alloc_old_dr), done: 1'b0});
        m_tail = (m_tail + 1) % DEPTH;
      end
      m_mask = m_mk;
      m_cnt  = m_n;
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_alloc_ready", 64'(alloc_ready), 64'(mq.size() < DEPTH));
      chk("model_alloc_tag", 64'(alloc_tag), 64'(m_tail));
      chk("model_rob_empty", 64'(rob_empty), 64'(mq.size() == 0));
      chk("model_mask", retire_preg_mask, m_mask);
      chk("model_retire_count", 64'(retire_count), 64'(m_cnt));
    end
  end

  task automatic drive(input bit av, input bit hd, input int dr, input int od,
                       input bit cv, input int ct);
    alloc_valid    = av;
    alloc_has_dest = hd;
    alloc_dr_p     = 6'(dr);
    alloc_old_dr   = 6'(od);
    cmpl_valid     = cv;
    cmpl_tag       = 16'(ct);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) idle();
    rstn = 1'b1;
  endtask

  initial begin
    int t;
    checks   = 0;
    failures = 0;
    model_ok = 1'b0;
    rstn     = 1'b0;
    alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_dr_p = '0; alloc_old_dr = '0;
    cmpl_valid = 1'b0; cmpl_tag = '0;

    // Reset then idle
    do_reset(2);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    chk("rst_rob_empty", 64'(rob_empty), 64'd1);
    chk("rst_mask", retire_preg_mask, 64'd0);
    chk("rst_count", 64'(retire_count), 64'd0);

    // Single instruction: allocate, complete next cycle, retire the cycle after
    drive(1'b1, 1'b1, 32, 5, 1'b0, 0);
    chk("single_alloc_tag_next", 64'(alloc_tag), 64'd1);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
    chk("single_no_early_retire", retire_preg_mask, 64'd0);
    idle();
    chk("single_mask", retire_preg_mask, 64'h20);
    chk("single_count", 64'(retire_count), 64'd1);
    chk("single_empty", 64'(rob_empty), 64'd1);
    idle();
    chk("single_mask_pulse", retire_preg_mask, 64'd0);
    chk("single_count_pulse", 64'(retire_count), 64'd0);

    // Out-of-order completion
    do_reset(1);
    drive(1'b1, 1'b1, 40, 7, 1'b0, 0);
    drive(1'b1, 1'b1, 41, 8, 1'b0, 0);
    drive(1'b1, 1'b1, 42, 9, 1'b0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 2);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1);
    chk("ooo_hold_1", retire_preg_mask, 64'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
    chk("ooo_hold_0", 64'(retire_count), 64'd0);
`ifdef ROB_DUAL_RETIRE_EN
    idle();
    chk("ooo_dual_mask_a", retire_preg_mask, 64'h180);
    chk("ooo_dual_count_a", 64'(retire_count), 64'd2);
    idle();
    chk("ooo_dual_mask_b", retire_preg_mask, 64'h200);
`else
    idle();
    chk("ooo_mask_7", retire_preg_mask, 64'h80);
    idle();
    chk("ooo_mask_8", retire_preg_mask, 64'h100);
    idle();
    chk("ooo_mask_9", retire_preg_mask, 64'h200);
`endif
    idle();
    chk("ooo_empty", 64'(rob_empty), 64'd1);

    // Full and wrap
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, i + 16, i + 1, 1'b0, 0);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    drive(1'b1, 1'b1, 63, 40, 1'b0, 0);
    chk("full_drop_ready", 64'(alloc_ready), 64'd0);
    chk("full_drop_tag", 64'(alloc_tag), 64'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
    chk("full_after_cmpl", 64'(alloc_ready), 64'd0);
    idle();
    chk("full_retire_mask", retire_preg_mask, 64'h2);
    chk("full_retire_ready", 64'(alloc_ready), 64'd1);
    chk("full_retire_tag", 64'(alloc_tag), 64'd0);
    drive(1'b1, 1'b1, 20, 50, 1'b0, 0);
    chk("wrap_full_again", 64'(alloc_ready), 64'd0);
    chk("wrap_tag", 64'(alloc_tag), 64'd1);
    for (int i = 1; i < DEPTH; i++) drive(1'b0, 1'b0, 0, 0, 1'b1, i);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
    repeat (3) idle();
    chk("lap1_empty", 64'(rob_empty), 64'd1);
    t = 1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, k, (k % 63) + 1, k > 0, (t + DEPTH - 1) % DEPTH);
      t = (t + 1) % DEPTH;
    end
    drive(1'b0, 1'b0, 0, 0, 1'b1, (t + DEPTH - 1) % DEPTH);
    repeat (3) idle();
    chk("lap2_empty", 64'(rob_empty), 64'd1);
    chk("lap2_tag", 64'(alloc_tag), 64'd5);

    // No-destination and physical register 0
    do_reset(1);
    drive(1'b1, 1'b0, 11, 3, 1'b0, 0);
    drive(1'b1, 1'b1, 12, 0, 1'b0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1);
    chk("nodest_count_a", 64'(retire_count), 64'd1);
    chk("nodest_mask_a", retire_preg_mask, 64'd0);
    idle();
    chk("nodest_count_b", 64'(retire_count), 64'd1);
    chk("nodest_mask_b", retire_preg_mask, 64'd0);

    // Reset mid-flight
    do_reset(1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 30 + i, 10 + i, 1'b0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 3);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 4);
    do_reset(1);
    chk("midrst_empty", 64'(rob_empty), 64'd1);
    chk("midrst_tag", 64'(alloc_tag), 64'd0);
    chk("midrst_mask", retire_preg_mask, 64'd0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0);
    idle();
    chk("midrst_stale_cmpl_mask", retire_preg_mask, 64'd0);
    chk("midrst_stale_cmpl_empty", 64'(rob_empty), 64'd1);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer that sits directly downstream of the rename stage in the out-of-order core. It allocates one entry per dispatched instruction, recording the new and previous physical destination registers. It marks entries complete when execution writes back and retires them strictly in program order. On retirement it drives a one-hot 64-bit physical-register release mask back to rename's free pool.

## Interface
Parameters:
- DEPTH, 16, number of entries; power of two, 4..64.
- PREG_W, 6, physical register index width (64 physical registers).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- alloc_valid  in  1  rename is dispatching one instruction this cycle.
- alloc_has_dest  in  1  instruction writes a register (low for stores/NOP).
- alloc_dr_p  in  PREG_W  new physical destination from rename.
- alloc_old_dr  in  PREG_W  previous mapping of the architectural destination.
- alloc_ready  out  1  entry available; low when full.
- alloc_tag  out  16  ROB index given to the accepted instruction, zero-extended; matches rename's ROB_num width.
- cmpl_valid  in  1  execution writeback for one instruction.
- cmpl_tag  in  16  ROB index being completed; only the low log2(DEPTH) bits are used.
- retire_preg_mask  out  64  one-hot-per-retire release mask of freed physical registers; registered.
- retire_count  out  2  number of instructions retired in the last cycle; registered.
- rob_empty  out  1  no valid entries.

## Operation
- Storage per entry: valid, done, has_dest, dr_p, old_dr.
- Pointers: head and tail, each log2(DEPTH)+1 bits, with the top bit used as a wrap flag. count is tail−head modulo 2·DEPTH. full = (count == DEPTH). empty = (count == 0).
- alloc_ready = !full. This is combinational from registered count; retirement in the same cycle does not bypass it.
- alloc_tag = tail index, combinational. It is valid whenever alloc_ready is high.
- Allocate on alloc_valid && alloc_ready:
  - Write the entry at tail with valid=1, done=0.
  - Increment tail. The index wraps DEPTH−1 → 0 and the wrap bit toggles.
  - alloc_valid while full is dropped. No state changes, and rename must stall.
- Complete on cmpl_valid:
  - Set done at cmpl_tag if that entry is valid.
  - Completion to an invalid entry is ignored.
  - Completing an already-done entry is harmless.
- Retire: the head entry retires when valid && done.
  - The entry is cleared and head increments.
  - If has_dest=1 and old_dr≠0, bit old_dr is set in next retire_preg_mask. Physical register 0 is never released.
  - Retirement decisions use registered done bits. A completion in cycle N is first retirable in cycle N+1.
- Simultaneous events:
  - Allocate, complete and retire may all occur in one cycle and update independent fields.
  - When full, a same-cycle retire frees an entry for the next cycle only.
- Reset: when rstn=0 at an edge:
  - head=tail=0 and all valid/done cleared.
  - retire_preg_mask=0, retire_count=0.
  - Resulting outputs: alloc_ready=1, alloc_tag=0, rob_empty=1.
  - Reset mid-operation discards all in-flight entries without releasing their registers.

## Timing
- Allocation latency: an entry accepted at edge E is visible for completion from cycle E+1.
- Minimum dispatch-to-release: allocate at edge E, complete at E+1, retire at E+2. retire_preg_mask is high for the single cycle following E+2.
- retire_preg_mask and retire_count are one-cycle pulses. They are 0 in any cycle with no retirement.
- Throughput: one allocation and one completion per cycle. Retirement is one per cycle, or two per cycle with the macro below.

## Configuration
- ROB_DUAL_RETIRE_EN defined:
  - Head+1 also retires in the same cycle if head retires and head+1 is valid && done.
  - Both old_dr bits are ORed into the mask. If both are equal (not possible in legal flow), the bit is simply set.
  - retire_count can be 2 and head advances by 2 with correct wrap.
- Undefined: at most one retire per cycle and retire_count ∈ {0,1}.

## Test plan
- Reset then idle: rstn low 2 cycles → alloc_ready=1, alloc_tag=0, rob_empty=1, retire_preg_mask=0.
- Single instruction: allocate dr_p=32, old_dr=5, complete tag 0 next cycle → retire_preg_mask=1<<5 for exactly one cycle, retire_count=1, rob_empty=1 after.
- Out-of-order completion: allocate tags 0,1,2 (old_dr 7,8,9), complete 2 then 1 then 0 → no retire until tag 0 is done. Then masks 1<<7, 1<<8, 1<<9 on consecutive cycles (single retire), or bits 7|8 followed by 9 (dual).
- Full and wrap: 16 allocations → alloc_ready=0, 17th alloc_valid ignored. Complete and retire tag 0 → next alloc_tag=0 accepted, and head/tail wrap correct through a second full lap.
- No-dest and x0: allocate has_dest=0 (old_dr=3) and has_dest=1 with old_dr=0, complete both → retire_count counts them, retire_preg_mask stays 0.
- Reset mid-flight: 5 entries, 2 done, assert rstn low → next cycle empty, retire_preg_mask=0, later completions to old tags ignored.
